// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between display scanout, a CPU port
// and a built-in full-memory clear engine. Display has priority; a stall counter bounds CPU wait.
`default_nettype none

module vram_arbiter #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_STALL  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_req,
  input  logic [ADDR_BITS-1:0]  disp_addr,
  output logic                  disp_gnt,
  output logic                  disp_valid,
  output logic [DATA_WIDTH-1:0] disp_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_BITS-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_valid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_value,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  ram_enable,
  output logic                  ram_write,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int STALL_W = $clog2(MAX_STALL + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  clr_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_addr_q, clr_addr_d;
  logic [DATA_WIDTH-1:0] clr_value_q, clr_value_d;
  logic                  clr_done_q, clr_done_d;
  logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [1:0]            rd_tag_q, rd_tag_d;

  logic clr_gnt;
  logic cpu_force;

  assign clr_busy = (state_q == ST_CLEAR);
  assign cpu_force = (stall_cnt_q == STALL_MAX) && !clr_busy;

  // Grants are gated by rst_n so nothing reaches the VRAM while in reset.
  assign disp_gnt = rst_n && disp_req && !(cpu_force && cpu_req);
  assign clr_gnt  = rst_n && clr_busy && !disp_req;
  assign cpu_gnt  = rst_n && cpu_req && !clr_busy && (!disp_req || cpu_force);

  always_comb begin
    ram_enable  = 1'b0;
    ram_write   = 1'b0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (disp_gnt) begin
      ram_enable = 1'b1;
      ram_addr   = disp_addr;
    end else if (clr_gnt) begin
      ram_enable  = 1'b1;
      ram_write   = 1'b1;
      ram_addr    = clr_addr_q;
      ram_data_in = clr_value_q;
    end else if (cpu_gnt) begin
      ram_enable  = 1'b1;
      ram_write   = cpu_we;
      ram_addr    = cpu_addr;
      ram_data_in = cpu_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_value_d = clr_value_q;
    clr_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = '0;
          clr_value_d = clr_value;
        end
      end
      ST_CLEAR: begin
        if (clr_gnt) begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == {ADDR_BITS{1'b1}}) begin
            state_d    = ST_IDLE;
            clr_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (cpu_gnt || clr_busy) begin
      stall_cnt_d = '0;
    end else if (cpu_req && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    rd_tag_d = {disp_gnt, cpu_gnt && !cpu_we};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= '0;
      clr_value_q <= '0;
      clr_done_q  <= 1'b0;
      stall_cnt_q <= '0;
      rd_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_value_q <= clr_value_d;
      clr_done_q  <= clr_done_d;
      stall_cnt_q <= stall_cnt_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  assign clr_done   = clr_done_q;
  assign disp_valid = rd_tag_q[1];
  assign cpu_valid  = rd_tag_q[0];
  assign disp_data  = ram_data_out;
  assign cpu_rdata  = ram_data_out;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus for vram_arbiter with a queue-based read-data
// scoreboard and a behavioural 1024x16 VRAM with one-cycle registered read.
`default_nettype none

module tb_vram_arbiter;
  localparam int AB    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AB-1:0] disp_addr = '0;
  logic          disp_gnt, disp_valid;
  logic [DW-1:0] disp_data;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AB-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_valid;
  logic [DW-1:0] cpu_rdata;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_value = '0;
  logic          clr_busy, clr_done;
  logic          ram_enable, ram_write;
  logic [AB-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_dout;

  logic [DW-1:0] mem [DEPTH];
  logic          do_init = 1'b1;
  int            wr_cnt;
  int            busy_cnt = 0, done_cnt = 0;
  int            errors = 0, checks = 0;
  logic [DW-1:0] cpu_q[$], disp_q[$];

  int n, m, bad, b0, d0, w0, viol_d, viol_c;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .MAX_STALL(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_enable(ram_enable), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_dout)
  );

  // VRAM model; preloaded with an address-dependent pattern so stale words are visible.
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i) ^ 16'h5A5A;
      wr_cnt <= 0;
    end else if (ram_enable) begin
      if (ram_write) begin
        mem[ram_addr] <= ram_data_in;
        wr_cnt <= wr_cnt + 1;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clr_busy) busy_cnt++;
    if (clr_done) done_cnt++;
    if (cpu_valid) begin
      if (cpu_q.size() == 0) check("cpu_valid_unexpected", 32'd1, 32'd0);
      else check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end
    if (disp_valid) begin
      if (disp_q.size() == 0) check("disp_valid_unexpected", 32'd1, 32'd0);
      else check("disp_data", 32'(disp_data), 32'(disp_q.pop_front()));
    end
  end

  initial begin
    // Reset state
    @(posedge clk);
    @(negedge clk);
    do_init = 1'b0;
    disp_req = 1'b1;
    cpu_req = 1'b1;
    #1;
    check("rst_gnts", {30'd0, disp_gnt, cpu_gnt}, 32'd0);
    check("rst_ram_enable", 32'(ram_enable), 32'd0);
    check("rst_flags", {28'd0, clr_busy, clr_done, disp_valid, cpu_valid}, 32'd0);
    disp_req = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // T1: lone CPU write then read
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0AB; cpu_wdata = 16'h1234;
    #1;
    check("t1_wr_gnt", 32'(cpu_gnt), 32'd1);
    check("t1_wr_ram", 32'({ram_enable, ram_write, ram_addr, ram_data_in}),
          32'({1'b1, 1'b1, 10'h0AB, 16'h1234}));
    @(negedge clk);
    cpu_we = 1'b0;
    #1;
    check("t1_rd_gnt", 32'(cpu_gnt), 32'd1);
    if (cpu_gnt) cpu_q.push_back(16'h1234);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    check("t1_idle_enable", 32'(ram_enable), 32'd0);

    // T2: display and CPU both held; CPU forced through every 9th cycle
    @(negedge clk);
    disp_req = 1'b1; disp_addr = 10'h0AB;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0AB;
    for (int i = 0; i < 27; i++) begin
      #1;
      check("t2_gnt", {30'd0, disp_gnt, cpu_gnt}, (i % 9 == 8) ? 32'd1 : 32'd2);
      if (disp_gnt) disp_q.push_back(16'h1234);
      if (cpu_gnt) cpu_q.push_back(16'h1234);
      @(negedge clk);
    end
    disp_req = 1'b0;
    cpu_req = 1'b0;

    // T3: full clear with no other traffic
    clr_value = 16'hBEEF;
    clr_start = 1'b1;
    #1;
    b0 = busy_cnt; d0 = done_cnt; w0 = wr_cnt;
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    while (!clr_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t3_done_timeout", 32'(n < 3000), 32'd1);
    @(negedge clk);
    #1;
    check("t3_busy_cycles", 32'(busy_cnt - b0), 32'd1024);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t3_writes", 32'(wr_cnt - w0), 32'd1024);
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== 16'hBEEF) bad++;
    check("t3_fill_bad_words", 32'(bad), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0;
      cpu_addr = (k == 0) ? 10'd0 : (k == 1) ? 10'd511 : 10'd1023;
      #1;
      check("t3_spot_gnt", 32'(cpu_gnt), 32'd1);
      if (cpu_gnt) cpu_q.push_back(16'hBEEF);
    end
    @(negedge clk);
    cpu_req = 1'b0;

    // T4: clear with toggling display and a held CPU write
    @(negedge clk);
    clr_value = 16'h1357; clr_start = 1'b1; disp_addr = 10'd1023;
    #1;
    d0 = done_cnt; w0 = wr_cnt;
    @(negedge clk);
    clr_start = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd5; cpu_wdata = 16'hAAAA;
    disp_req = 1'b1;
    viol_d = 0; viol_c = 0; n = 0;
    while (clr_busy && n < 5000) begin
      #1;
      if (disp_gnt !== disp_req) viol_d++;
      if (cpu_gnt) viol_c++;
      if (disp_gnt) disp_q.push_back(16'hBEEF);
      @(negedge clk);
      disp_req = ~disp_req;
      n++;
    end
    check("t4_busy_timeout", 32'(n < 5000), 32'd1);
    check("t4_disp_blocked", 32'(viol_d), 32'd0);
    check("t4_cpu_gnt_while_busy", 32'(viol_c), 32'd0);
    disp_req = 1'b0;
    #1;
    check("t4_cpu_gnt_after", 32'(cpu_gnt), 32'd1);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    check("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t4_writes", 32'(wr_cnt - w0), 32'd1025);
    bad = 0;
    for (int a = 0; a < DEPTH; a++)
      if (mem[a] !== ((a == 5) ? 16'hAAAA : 16'h1357)) bad++;
    check("t4_fill_bad_words", 32'(bad), 32'd0);

    // T5: reset in the middle of a clear
    @(negedge clk);
    clr_value = 16'h2468; clr_start = 1'b1;
    #1;
    d0 = done_cnt;
    @(negedge clk);
    clr_start = 1'b0;
    n = 0;
    #1;
    while (!(ram_enable && ram_write && ram_addr == 10'd300) && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_addr300_timeout", 32'(n < 2000), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(clr_busy), 32'd0);
    check("t5_rst_ram_enable", 32'(ram_enable), 32'd0);
    disp_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    #1;
    check("t5_rst_gnts", {30'd0, disp_gnt, cpu_gnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    disp_req = 1'b0; cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_busy_after", 32'(clr_busy), 32'd0);
    check("t5_mem299", 32'(mem[299]), 32'h2468);
    check("t5_mem300", 32'(mem[300]), 32'h1357);
    @(negedge clk);
    clr_value = 16'h1111; clr_start = 1'b1;
    #1;
    d0 = done_cnt;
    @(negedge clk);
    clr_start = 1'b0;
    #1;
    check("t5_restart_ram", 32'({ram_enable, ram_write, ram_addr, ram_data_in}),
          32'({1'b1, 1'b1, 10'd0, 16'h1111}));
    n = 0;
    while (!clr_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_done_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
    #1;
    check("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t5_mem1023", 32'(mem[1023]), 32'h1111);

    repeat (2) @(negedge clk);
    #1;
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("disp_q_drained", 32'(disp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
